// File: rtl/anim_platform_array_pkg.sv
// Platform descriptors, FSM state encoding and tile constants for the
// animated platform overlay.
package platformPkg;

    localparam int          MAX_PLAT        = 8;
    localparam int          TILE_W          = 64;
    localparam int          TILE_H          = 32;
    localparam logic [11:0] TRANSPARENT_RGB = 12'hF0F;

    typedef enum logic [1:0] {
        SOLID = 2'd0,
        SHAKE = 2'd1,
        FALL  = 2'd2,
        GONE  = 2'd3
    } plat_state_t;

    typedef struct packed {
        logic [10:0] y_top;
        logic [10:0] x_start;
        logic [10:0] x_end;    // exclusive right edge
        logic [4:0]  rom_row;  // first tile ROM row used by this platform
    } plat_desc_t;

    localparam plat_desc_t PLAT_TABLE [MAX_PLAT] = '{
        '{y_top: 11'd736, x_start: 11'd0,   x_end: 11'd128,  rom_row: 5'd0 },
        '{y_top: 11'd600, x_start: 11'd100, x_end: 11'd300,  rom_row: 5'd4 },
        '{y_top: 11'd700, x_start: 11'd400, x_end: 11'd500,  rom_row: 5'd8 },
        '{y_top: 11'd610, x_start: 11'd200, x_end: 11'd400,  rom_row: 5'd12},
        '{y_top: 11'd400, x_start: 11'd600, x_end: 11'd800,  rom_row: 5'd16},
        '{y_top: 11'd300, x_start: 11'd800, x_end: 11'd1000, rom_row: 5'd20},
        '{y_top: 11'd200, x_start: 11'd100, x_end: 11'd200,  rom_row: 5'd24},
        '{y_top: 11'd100, x_start: 11'd300, x_end: 11'd400,  rom_row: 5'd28}
    };

endpackage

// File: rtl/vga_pkg.sv
// Display geometry shared by the video blocks.
package vgaPkg;

    localparam logic [10:0] HOR_PIXELS = 11'd1024;
    localparam logic [10:0] VER_PIXELS = 11'd768;

endpackage

// File: rtl/vga_if.sv
// VGA timing and colour stream bundle.
interface vga_if;

    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);

endinterface

// File: rtl/delay.sv
// Fixed-length shift register used to align parallel video pipelines.
module delay #(
    parameter int WIDTH   = 8,
    parameter int CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_r [CLK_DEL];

    // Shift the data one stage per clock, clearing every stage on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CLK_DEL; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= din;
            for (int i = 1; i < CLK_DEL; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign dout = pipe_r[CLK_DEL-1];

endmodule

// File: rtl/platform_fsm.sv
// Collapse sequencer for one platform: SOLID -> SHAKE -> FALL -> GONE,
// advancing only on the frame tick and producing the draw offsets.
module platform_fsm
    import platformPkg::*;
    import vgaPkg::*;
#(
    parameter int SHAKE_FRAMES = 16,
    parameter int FALL_STEP    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              tick,
    input  logic              req,
    input  logic [10:0]       y_top,
    output plat_state_t       state,
    output logic signed [2:0] x_off,
    output logic [10:0]       y_off
);

    // At least two bits so that the shake direction bit always exists.
    localparam int CNT_W = (SHAKE_FRAMES > 4) ? $clog2(SHAKE_FRAMES) : 2;

    plat_state_t       state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic signed [2:0] x_off_r, x_off_s;
    logic [10:0]       y_off_r, y_off_s;
    logic [11:0]       y_step_s;
    logic [10:0]       y_sat_s;
    logic [11:0]       y_bot_s;

    // Next-state, shake counter and offset computation.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        y_off_s  = y_off_r;
        y_step_s = {1'b0, y_off_r} + 12'(FALL_STEP);
        y_sat_s  = y_step_s[11] ? 11'h7FF : y_step_s[10:0];
        y_bot_s  = {1'b0, y_top} + {1'b0, y_sat_s};

        if (!enable) begin
            state_s = SOLID;
            cnt_s   = '0;
            y_off_s = 11'd0;
        end else if (tick) begin
            case (state_r)
                SOLID: begin
                    if (req) begin
                        state_s = SHAKE;
                        cnt_s   = '0;
                    end else begin
                        state_s = SOLID;
                    end
                end
                SHAKE: begin
                    if (cnt_r == CNT_W'(SHAKE_FRAMES - 1)) begin
                        state_s = FALL;
                        cnt_s   = '0;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                FALL: begin
                    // GONE is decided on the offset that takes effect this frame.
                    y_off_s = y_sat_s;
                    if (y_bot_s >= {1'b0, VER_PIXELS}) begin
                        state_s = GONE;
                    end else begin
                        state_s = FALL;
                    end
                end
                GONE: begin
                    state_s = GONE;
                end
                default: begin
                    state_s = SOLID;
                    cnt_s   = '0;
                    y_off_s = 11'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end

        if (state_s == SHAKE) begin
            x_off_s = cnt_s[1] ? -3'sd2 : 3'sd2;
        end else begin
            x_off_s = 3'sd0;
        end
    end

    // State and offset registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= SOLID;
            cnt_r   <= '0;
            x_off_r <= 3'sd0;
            y_off_r <= 11'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            x_off_r <= x_off_s;
            y_off_r <= y_off_s;
        end
    end

    assign state = state_r;
    assign x_off = x_off_r;
    assign y_off = y_off_r;

endmodule

// File: rtl/anim_platform_array.sv
// Overlays up to eight animated tile platforms on a VGA stream. Hit test and
// ROM address happen in stage 0, ROM data returns in stage 2, and the mixed
// pixel is registered in stage 3 together with the delayed timing fields.
module anim_platform_array
    import platformPkg::*;
    import vgaPkg::*;
#(
    parameter int N_PLAT       = 6,
    parameter int SHAKE_FRAMES = 16,
    parameter int FALL_STEP    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_game,
    input  logic [N_PLAT-1:0] collapse_req,
    input  logic [11:0]       rgb_pixel,
    output logic [10:0]       pixel_addr,
    output logic [N_PLAT-1:0] plat_gone,
    vga_if.in                 in,
    vga_if.out                out
);

    localparam int DLY_W = 40;

    logic              tick_s;
    logic              draw_s;
    logic [N_PLAT-1:0] hit_s;
    logic [10:0]       addr_s [N_PLAT];
    logic              any_hit_s;
    logic [10:0]       sel_addr_s;
    logic [10:0]       pixel_addr_r;
    logic signed [12:0] v_s, h_s;

    logic [DLY_W-1:0]  dly_s;
    logic [10:0]       vcount_d, hcount_d;
    logic              vsync_d, vblnk_d, hsync_d, hblnk_d, hit_d, en_d;
    logic [11:0]       rgb_d;
    logic [11:0]       rgb_s;

    assign tick_s = (in.vcount == 11'd0) && (in.hcount == 11'd0);
    assign draw_s = start_game & ~(in.vblnk | in.hblnk);
    assign v_s    = $signed({2'b00, in.vcount});
    assign h_s    = $signed({2'b00, in.hcount});

    for (genvar i = 0; i < N_PLAT; i++) begin : g_plat
        plat_state_t        state_s;
        logic signed [2:0]  x_off_s;
        logic [10:0]        y_off_s;
        logic signed [12:0] y_eff_s, x_eff_s, x_lim_s, dy_s, dx_s;
        logic [4:0]         row_s;

        platform_fsm #(
            .SHAKE_FRAMES (SHAKE_FRAMES),
            .FALL_STEP    (FALL_STEP)
        ) u_fsm (
            .clk    (clk),
            .rst    (rst),
            .enable (start_game),
            .tick   (tick_s),
            .req    (collapse_req[i]),
            .y_top  (PLAT_TABLE[i].y_top),
            .state  (state_s),
            .x_off  (x_off_s),
            .y_off  (y_off_s)
        );

        assign y_eff_s = $signed({2'b00, PLAT_TABLE[i].y_top}) + $signed({2'b00, y_off_s});
        assign x_eff_s = $signed({2'b00, PLAT_TABLE[i].x_start}) + $signed({{10{x_off_s[2]}}, x_off_s});
        assign x_lim_s = $signed({2'b00, PLAT_TABLE[i].x_end}) + $signed({{10{x_off_s[2]}}, x_off_s});
        assign dy_s    = v_s - y_eff_s;
        assign dx_s    = h_s - x_eff_s;
        assign row_s   = dy_s[4:0] + PLAT_TABLE[i].rom_row;

        assign hit_s[i] = draw_s && (state_s != GONE)
                       && (v_s >= y_eff_s) && (v_s < y_eff_s + $signed(13'(TILE_H)))
                       && (h_s >= x_eff_s) && (h_s < x_lim_s);
        assign addr_s[i]    = {row_s, dx_s[5:0]};
        assign plat_gone[i] = (state_s == GONE);
    end

    // Priority select: scanning downward leaves the lowest hitting index.
    always_comb begin
        any_hit_s  = 1'b0;
        sel_addr_s = pixel_addr_r;
        for (int i = N_PLAT - 1; i >= 0; i--) begin
            if (hit_s[i]) begin
                any_hit_s  = 1'b1;
                sel_addr_s = addr_s[i];
            end else begin
                any_hit_s = any_hit_s;
            end
        end
    end

    // Tile ROM address register; holds its value on pixels with no hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_addr_r <= 11'd0;
        end else begin
            pixel_addr_r <= sel_addr_s;
        end
    end

    assign pixel_addr = pixel_addr_r;

    delay #(
        .WIDTH   (DLY_W),
        .CLK_DEL (2)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({in.vcount, in.vsync, in.vblnk, in.hcount, in.hsync, in.hblnk,
                in.rgb, any_hit_s, start_game}),
        .dout (dly_s)
    );

    assign {vcount_d, vsync_d, vblnk_d, hcount_d, hsync_d, hblnk_d,
            rgb_d, hit_d, en_d} = dly_s;

    // Colour mix once the ROM data for the delayed pixel is available.
    always_comb begin
        rgb_s = rgb_d;
        if (!en_d) begin
            rgb_s = rgb_d;
        end else if (vblnk_d || hblnk_d) begin
            rgb_s = 12'h888;
        end else if (hit_d && (rgb_pixel != TRANSPARENT_RGB)) begin
            rgb_s = rgb_pixel;
        end else begin
            rgb_s = rgb_d;
        end
    end

    // Output stream register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out.vcount <= 11'd0;
            out.vsync  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.hcount <= 11'd0;
            out.hsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.rgb    <= 12'h000;
        end else begin
            out.vcount <= vcount_d;
            out.vsync  <= vsync_d;
            out.vblnk  <= vblnk_d;
            out.hcount <= hcount_d;
            out.hsync  <= hsync_d;
            out.hblnk  <= hblnk_d;
            out.rgb    <= rgb_s;
        end
    end

endmodule

// File: tb/tb_anim_platform_array.sv
// Self-checking bench for anim_platform_array: table of single pixels with
// hand-computed ROM addresses, plus collapse/reset/start_game sequences.
module tb_anim_platform_array;

    localparam int          N           = 6;
    localparam logic [10:0] TRANSP_ADDR = 11'h10A;
    localparam logic [11:0] IDLE_RGB    = 12'hABC;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_game;
    logic [N-1:0] collapse_req;
    logic [11:0]  rgb_pixel;
    logic [10:0]  pixel_addr;
    logic [N-1:0] plat_gone;

    vga_if vin();
    vga_if vout();

    anim_platform_array #(
        .N_PLAT       (N),
        .SHAKE_FRAMES (16),
        .FALL_STEP    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_game   (start_game),
        .collapse_req (collapse_req),
        .rgb_pixel    (rgb_pixel),
        .pixel_addr   (pixel_addr),
        .plat_gone    (plat_gone),
        .in           (vin),
        .out          (vout)
    );

    always #5 clk = ~clk;

    // Tile ROM model: one clock read latency, one address reads transparent.
    always @(posedge clk) begin
        rgb_pixel <= (pixel_addr == TRANSP_ADDR) ? 12'hF0F : {1'b0, pixel_addr};
    end

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic [10:0] vc;
        logic [10:0] hc;
        logic        hb;
    } exp_out_t;

    typedef struct {
        int          due;
        logic [10:0] addr;
    } exp_addr_t;

    typedef struct {
        logic [10:0] v;
        logic [10:0] h;
        logic        blnk;
        logic [11:0] rgb;
        logic [11:0] erg;
        logic [10:0] ea;
    } vec_t;

    exp_out_t  out_q[$];
    exp_addr_t addr_q[$];
    vec_t      tbl [15];

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic cycle();
        exp_out_t  eo;
        exp_addr_t ea;
        @(posedge clk);
        #1;
        cyc++;
        while (out_q.size() > 0 && out_q[0].due <= cyc) begin
            eo = out_q.pop_front();
            chk("out_rgb", {20'd0, vout.rgb}, {20'd0, eo.rgb});
            chk("out_timing", {9'd0, vout.vcount, vout.hcount, vout.hblnk},
                {9'd0, eo.vc, eo.hc, eo.hb});
        end
        while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
            ea = addr_q.pop_front();
            chk("pixel_addr", {21'd0, pixel_addr}, {21'd0, ea.addr});
        end
    endtask

    task automatic drive(input logic [10:0] v, input logic [10:0] h, input logic blnk,
                         input logic [11:0] rgb, input logic [11:0] erg,
                         input logic ca, input logic [10:0] ea);
        exp_out_t  eo;
        exp_addr_t xa;
        vin.vcount = v;
        vin.hcount = h;
        vin.hblnk  = blnk;
        vin.rgb    = rgb;
        eo.due = cyc + 3; eo.rgb = erg; eo.vc = v; eo.hc = h; eo.hb = blnk;
        out_q.push_back(eo);
        if (ca) begin
            xa.due = cyc + 1; xa.addr = ea;
            addr_q.push_back(xa);
        end
        cycle();
    endtask

    task automatic idle(input int n);
        vin.vcount = 11'd800;
        vin.hcount = 11'd1100;
        vin.hblnk  = 1'b0;
        vin.rgb    = IDLE_RGB;
        repeat (n) cycle();
    endtask

    task automatic tick();
        vin.vcount = 11'd0;
        vin.hcount = 11'd0;
        vin.hblnk  = 1'b0;
        vin.rgb    = IDLE_RGB;
        cycle();
        idle(1);
    endtask

    initial begin
        int xo;
        int yv;

        tbl[0]  = '{11'd736, 11'd5,   1'b0, 12'hC00, 12'h005, 11'h005};
        tbl[1]  = '{11'd767, 11'd70,  1'b0, 12'hC01, 12'h7C6, 11'h7C6};
        tbl[2]  = '{11'd735, 11'd5,   1'b0, 12'hC02, 12'hC02, 11'h7C6};
        tbl[3]  = '{11'd750, 11'd128, 1'b0, 12'hC03, 12'hC03, 11'h7C6};
        tbl[4]  = '{11'd750, 11'd127, 1'b0, 12'hC04, 12'h3BF, 11'h3BF};
        tbl[5]  = '{11'd740, 11'd10,  1'b0, 12'hC05, 12'hC05, 11'h10A};
        tbl[6]  = '{11'd615, 11'd250, 1'b0, 12'hC06, 12'h4D6, 11'h4D6};
        tbl[7]  = '{11'd615, 11'd350, 1'b0, 12'hC07, 12'h456, 11'h456};
        tbl[8]  = '{11'd605, 11'd250, 1'b0, 12'hC08, 12'h256, 11'h256};
        tbl[9]  = '{11'd630, 11'd100, 1'b0, 12'hC09, 12'h080, 11'h080};
        tbl[10] = '{11'd431, 11'd600, 1'b0, 12'hC0A, 12'h3C0, 11'h3C0};
        tbl[11] = '{11'd300, 11'd863, 1'b0, 12'hC0B, 12'h53F, 11'h53F};
        tbl[12] = '{11'd200, 11'd150, 1'b0, 12'hC0C, 12'hC0C, 11'h53F};
        tbl[13] = '{11'd736, 11'd6,   1'b1, 12'hC0D, 12'h888, 11'h53F};
        tbl[14] = '{11'd736, 11'd7,   1'b0, 12'hC0E, 12'h007, 11'h007};

        rst          = 1'b1;
        start_game   = 1'b0;
        collapse_req = '0;
        vin.vsync    = 1'b0;
        vin.vblnk    = 1'b0;
        vin.hsync    = 1'b0;
        idle(3);
        chk("rst_out_rgb", {20'd0, vout.rgb}, 32'd0);
        chk("rst_out_vcount", {21'd0, vout.vcount}, 32'd0);
        chk("rst_pixel_addr", {21'd0, pixel_addr}, 32'd0);
        chk("rst_plat_gone", {26'd0, plat_gone}, 32'd0);
        rst = 1'b0;

        // start_game low: no overlay even on a platform pixel.
        drive(11'd736, 11'd5, 1'b0, 12'hC10, 12'hC10, 1'b0, 11'd0);
        idle(4);

        start_game = 1'b1;
        idle(2);
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v, tbl[i].h, tbl[i].blnk, tbl[i].rgb, tbl[i].erg, 1'b1, tbl[i].ea);
        end
        idle(4);

        // Collapse platform 2 with a one-clock request across the tick.
        collapse_req = 6'b000100;
        tick();
        collapse_req = '0;
        for (int k = 0; k < 16; k++) begin
            xo = (k[1] == 1'b0) ? 2 : -2;
            drive(11'd700, 11'(400 + xo), 1'b0, 12'hD00, 12'h200, 1'b1, 11'h200);
            drive(11'd700, 11'(500 + xo), 1'b0, 12'hD01, 12'hD01, 1'b0, 11'd0);
            tick();
        end
        for (int j = 0; j < 17; j++) begin
            yv = 700 + 4 * j;
            drive(11'(yv), 11'd400, 1'b0, 12'hD02, 12'h200, 1'b1, 11'h200);
            drive(11'(yv - 1), 11'd400, 1'b0, 12'hD03, 12'hD03, 1'b0, 11'd0);
            if (j == 16) begin
                chk("gone_not_yet", {26'd0, plat_gone}, 32'd0);
            end
            tick();
        end
        chk("gone_after_fall", {26'd0, plat_gone}, {26'd0, 6'b000100});
        collapse_req = 6'b000100;
        tick();
        collapse_req = '0;
        chk("gone_ignores_req", {26'd0, plat_gone}, {26'd0, 6'b000100});

        // Dropping start_game restores every platform.
        start_game = 1'b0;
        idle(2);
        chk("stop_clears_gone", {26'd0, plat_gone}, 32'd0);
        start_game = 1'b1;
        idle(1);
        drive(11'd700, 11'd400, 1'b0, 12'hD04, 12'h200, 1'b1, 11'h200);
        drive(11'd700, 11'd399, 1'b0, 12'hD05, 12'hD05, 1'b0, 11'd0);
        idle(4);

        // Reset in the middle of a fall.
        collapse_req = 6'b000100;
        tick();
        collapse_req = '0;
        for (int k = 0; k < 19; k++) begin
            tick();
        end
        drive(11'd712, 11'd400, 1'b0, 12'hD06, 12'h200, 1'b1, 11'h200);
        drive(11'd700, 11'd400, 1'b0, 12'hD07, 12'hD07, 1'b0, 11'd0);
        idle(4);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midfall_rst_rgb", {20'd0, vout.rgb}, 32'd0);
        chk("midfall_rst_addr", {21'd0, pixel_addr}, 32'd0);
        chk("midfall_rst_gone", {26'd0, plat_gone}, 32'd0);
        drive(11'd700, 11'd400, 1'b0, 12'hD08, 12'h200, 1'b1, 11'h200);
        drive(11'd699, 11'd400, 1'b0, 12'hD09, 12'hD09, 1'b0, 11'd0);

        for (int i = 0; i < 10; i++) begin
            if (out_q.size() > 0 || addr_q.size() > 0) begin
                idle(1);
            end
        end
        chk("scoreboard_drained", 32'(out_q.size() + addr_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
